motor_status_tx: RTL and testbench

Host-bound UART transmitter for the motor controller. It serialises a status frame of the same shape the host uses for position commands: sync byte `"S"` (8'h53), motor index byte, position byte. Frames go out 8N1 at 230400 baud from the 10 MHz board clock. It sits beside the command receiver in the top level, and its TxD drives a spare connector-B pin back to the host.

---
 rtl/motor_uart_pkg.sv | 28 ++
 rtl/uart_tx_byte.sv | 82 ++++++++
 rtl/motor_status_tx.sv | 138 +++++++++++++
 tb/tb_motor_status_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : motor_uart_pkg
//  Description : Shared constants, frame-state enum and bit-period helper for
//                the motor controller UART paths (status TX, command RX).
//  Revision    : 1.0 - initial release
// ============================================================================
package motor_uart_pkg;

    localparam logic [7:0] SYNC_CHAR = 8'h53;
    localparam int         CLK_HZ    = 10000000;
    localparam int         BAUD      = 230400;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_INDEX = 3'd2,
        ST_POS   = 3'd3,
        ST_CHK   = 3'd4
    } frame_state_t;

    // Clock cycles per bit, rounded to the nearest whole cycle
    function automatic int bit_cycles(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 byte serialiser. A load starts the start bit on the very
//                next cycle; byteDone is high during the last cycle of the
//                stop bit so the owner can load the next byte back-to-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int BIT_CYCLES = 43
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       idle,
    output logic       byteDone,
    output logic       TxD
);

    localparam int               CNT_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT  = 4'd9;

    logic             busy;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       shift;
    logic [9:0]       shift_next;
    logic             bit_end;
    logic             byte_end;

    assign bit_end  = busy && (baud_cnt == BAUD_LAST);
    assign byte_end = bit_end && (bit_cnt == LAST_BIT);
    assign idle     = ~busy;
    assign byteDone = byte_end;

    // Shift register holds {stop, D7..D0, start}; bit 0 is the bit on the line
    always_comb begin
        shift_next = shift;
        if (load) begin
            shift_next = {1'b1, data, 1'b0};
        end else if (bit_end && !byte_end) begin
            shift_next = {1'b1, shift[9:1]};
        end
    end

    // Baud/bit counters and the registered line driver
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '1;
            TxD      <= 1'b1;
        end else begin
            shift <= shift_next;
            if (load) begin
                busy     <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                TxD      <= shift_next[0];
            end else if (byte_end) begin
                busy     <= 1'b0;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                TxD      <= 1'b1;
            end else if (bit_end) begin
                baud_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
                TxD      <= shift_next[0];
            end else if (busy) begin
                baud_cnt <= baud_cnt + CNT_W'(1);
                TxD      <= shift_next[0];
            end else begin
                TxD      <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/motor_status_tx.sv
`default_nettype none
// ============================================================================
//  Module      : motor_status_tx
//  Description : Host-bound status frame transmitter: "S", motor index, pos
//                (and optional XOR checksum) sent 8N1 back-to-back.
//                Optional feature macro: MOTOR_STATUS_TX_CHECKSUM_EN adds a
//                fourth byte CHK = 8'h53 ^ {4'h0, motorIdx} ^ pos.
//  Revision    : 1.0 - initial release
// ============================================================================
module motor_status_tx
    import motor_uart_pkg::*;
#(
    parameter int ClkFrequency = CLK_HZ,
    parameter int Baud         = BAUD
) (
    input  logic       CLK_10MHZ,
    input  logic       RST,
    input  logic       send,
    input  logic [3:0] motorIdx,
    input  logic [7:0] pos,
    output logic       ready,
    output logic       TxD,
    output logic       done
);

    localparam int BIT_CYCLES = bit_cycles(ClkFrequency, Baud);

    frame_state_t state;
    frame_state_t state_next;
    logic [3:0]   frame_idx;
    logic [7:0]   frame_pos;
    logic         load;
    logic [7:0]   tx_data;
    logic         capture;
    logic         done_next;
    logic         tx_idle;
    logic         byte_done;

`ifdef MOTOR_STATUS_TX_CHECKSUM_EN
    logic [7:0] chk_byte;
    assign chk_byte = SYNC_CHAR ^ {4'h0, frame_idx} ^ frame_pos;
`endif

    // Idle means no frame in flight and the serialiser has drained
    assign ready = (state == ST_IDLE) && tx_idle;

    // Byte sequencing: load the next byte on the edge the previous one ends
    always_comb begin
        state_next = state;
        load       = 1'b0;
        tx_data    = SYNC_CHAR;
        capture    = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (send && tx_idle) begin
                    load       = 1'b1;
                    tx_data    = SYNC_CHAR;
                    capture    = 1'b1;
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (byte_done) begin
                    load       = 1'b1;
                    tx_data    = {4'h0, frame_idx};
                    state_next = ST_INDEX;
                end
            end
            ST_INDEX: begin
                if (byte_done) begin
                    load       = 1'b1;
                    tx_data    = frame_pos;
                    state_next = ST_POS;
                end
            end
            ST_POS: begin
                if (byte_done) begin
`ifdef MOTOR_STATUS_TX_CHECKSUM_EN
                    load       = 1'b1;
                    tx_data    = chk_byte;
                    state_next = ST_CHK;
`else
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef MOTOR_STATUS_TX_CHECKSUM_EN
            ST_CHK: begin
                if (byte_done) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame state register and the registered done pulse
    always_ff @(posedge CLK_10MHZ or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // Snapshot of the request so later input changes cannot corrupt the frame
    always_ff @(posedge CLK_10MHZ or posedge RST) begin
        if (RST) begin
            frame_idx <= '0;
            frame_pos <= '0;
        end else if (capture) begin
            frame_idx <= motorIdx;
            frame_pos <= pos;
        end
    end

    uart_tx_byte #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_tx (
        .clk      (CLK_10MHZ),
        .rst      (RST),
        .load     (load),
        .data     (tx_data),
        .idle     (tx_idle),
        .byteDone (byte_done),
        .TxD      (TxD)
    );

endmodule
`default_nettype wire

// File: tb/tb_motor_status_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_status_tx
//  Description : Scoreboard bench for motor_status_tx. The driver predicts
//                accepted frames and queues expected bytes, byte start times
//                and done cycles; a line receiver and done monitor check them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_status_tx;

    localparam int TB_CLK_HZ = 10000000;
    localparam int TB_BAUD   = 230400;
    localparam int BC        = (TB_CLK_HZ + TB_BAUD / 2) / TB_BAUD;
`ifdef MOTOR_STATUS_TX_CHECKSUM_EN
    localparam int NBYTES    = 4;
`else
    localparam int NBYTES    = 3;
`endif
    localparam int FRAME     = NBYTES * 10 * BC;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic [3:0] idx;
    logic [7:0] pos;
    logic       ready;
    logic       txd;
    logic       done;

    motor_status_tx #(
        .ClkFrequency (TB_CLK_HZ),
        .Baud         (TB_BAUD)
    ) dut (
        .CLK_10MHZ (clk),
        .RST       (rst),
        .send      (send),
        .motorIdx  (idx),
        .pos       (pos),
        .ready     (ready),
        .TxD       (txd),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    logic [7:0] exp_byte[$];
    int         exp_start[$];
    int         exp_done[$];
    int         acc_at = -100000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: ready is low for FRAME cycles starting with the first start bit
    function automatic logic model_ready(input int c);
        return !(c >= acc_at && c < acc_at + FRAME);
    endfunction

    // One cycle of stimulus; predicts whether the DUT accepts it
    task automatic drive(input logic s, input logic [3:0] i, input logic [7:0] p);
        logic [7:0] b [4];
        int a;
        @(posedge clk);
        #1;
        send = s;
        idx  = i;
        pos  = p;
        if (s && model_ready(cyc)) begin
            a      = cyc + 1;
            acc_at = a;
            b[0]   = 8'h53;
            b[1]   = {4'h0, i};
            b[2]   = p;
            b[3]   = 8'h53 ^ {4'h0, i} ^ p;
            for (int j = 0; j < NBYTES; j++) begin
                exp_byte.push_back(b[j]);
                exp_start.push_back(a + j * 10 * BC);
            end
            exp_done.push_back(a + FRAME);
        end
    endtask

    task automatic idle_cycles(input int n, input logic [3:0] i, input logic [7:0] p);
        for (int k = 0; k < n; k++) drive(1'b0, i, p);
    endtask

    // Monitor: ready vs model, done timing, and a mid-bit sampling receiver
    int         rx_t;
    int         rx_start;
    bit         rx_active = 1'b0;
    logic [7:0] rx_data;
    always @(negedge clk) begin
        int bitn;
        if (rst) begin
            rx_active = 1'b0;
        end else begin
            chk("ready", ready, model_ready(cyc));
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done at cycle %0d: got pulse, expected none", cyc);
                end else begin
                    chk("done_cycle", cyc, exp_done.pop_front());
                end
            end
            if (!rx_active && txd == 1'b0) begin
                rx_active = 1'b1;
                rx_t      = 0;
                rx_start  = cyc;
            end
            if (rx_active) begin
                if (rx_t % BC == BC / 2) begin
                    bitn = rx_t / BC;
                    if (bitn == 0) begin
                        chk("start_bit", txd, 1'b0);
                    end else if (bitn <= 8) begin
                        rx_data[bitn-1] = txd;
                    end else begin
                        chk("stop_bit", txd, 1'b1);
                        rx_active = 1'b0;
                        if (exp_byte.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL byte at cycle %0d: got %0h, expected none", cyc, rx_data);
                        end else begin
                            chk("byte", rx_data, exp_byte.pop_front());
                            chk("byte_start", rx_start, exp_start.pop_front());
                        end
                    end
                end
                rx_t++;
            end
        end
    end

    initial begin
        rst  = 1'b1;
        send = 1'b0;
        idx  = 4'd0;
        pos  = 8'd0;
        #1;
        chk("reset_ready", ready, 1'b1);
        chk("reset_txd", txd, 1'b1);
        chk("reset_done", done, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic frame: index 3, pos A5
        drive(1'b1, 4'd3, 8'hA5);
        idle_cycles(FRAME + 20, 4'd3, 8'hA5);

        // Second send mid-frame is ignored
        drive(1'b1, 4'd5, 8'h3C);
        idle_cycles(498, 4'd5, 8'h3C);
        drive(1'b1, 4'd7, 8'h77);
        idle_cycles(FRAME, 4'd7, 8'h77);

        // Inputs change shortly after acceptance
        drive(1'b1, 4'd3, 8'hA5);
        idle_cycles(9, 4'd3, 8'hA5);
        idle_cycles(FRAME + 10, 4'd9, 8'h11);

        // send held high: back-to-back frames, one idle clock at each done
        for (int k = 0; k < 3000; k++)
            drive(1'b1, 4'($urandom_range(0, 11)), 8'($urandom));
        idle_cycles(FRAME + 10, 4'd0, 8'd0);

        // Randomised requests, including many while busy
        for (int k = 0; k < 15000; k++)
            drive($urandom_range(0, 99) < 2, 4'($urandom_range(0, 11)), 8'($urandom));
        idle_cycles(FRAME + 10, 4'd0, 8'd0);

        // Reset mid-frame, then a clean frame
        drive(1'b1, 4'd3, 8'hA5);
        idle_cycles(698, 4'd3, 8'hA5);
        @(posedge clk);
        #2;
        exp_byte.delete();
        exp_start.delete();
        exp_done.delete();
        acc_at = -100000;
        rst    = 1'b1;
        #1;
        chk("midreset_txd", txd, 1'b1);
        chk("midreset_ready", ready, 1'b1);
        chk("midreset_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(5, 4'd0, 8'd0);
        drive(1'b1, 4'd3, 8'hA5);
        idle_cycles(FRAME + 20, 4'd3, 8'hA5);

        chk("leftover_bytes", exp_byte.size(), 0);
        chk("leftover_done", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
